// File: rtl/prog_loader.sv
// Boot-image loader: streams words into a single-port synchronous RAM, reads the
// image back to verify its checksum, then releases the CPU at the image base.
module prog_loader #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic [DATA_WIDTH-1:0] expected_sum,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  cpu_run,
    output logic [ADDR_WIDTH-1:0] start_pc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_VADDR,
        S_VDATA,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [ADDR_WIDTH:0]   MAX_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = '0;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] SUM_ZERO  = '0;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_ptr;
    logic [ADDR_WIDTH:0]     r_rem;
    logic [ADDR_WIDTH:0]     r_count;
    logic [ADDR_WIDTH-1:0]   r_base;
    logic [DATA_WIDTH-1:0]   r_exp;
    logic [DATA_WIDTH-1:0]   r_load_sum;
    logic [DATA_WIDTH-1:0]   r_rd_sum;

    logic                    r_in_ready;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [DATA_WIDTH-1:0]   r_mem_wdata;
    logic                    r_mem_cs;
    logic                    r_mem_we;
    logic                    r_mem_oe;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_err;
    logic                    r_cpu_run;
    logic [ADDR_WIDTH-1:0]   r_start_pc;

    logic [ADDR_WIDTH:0]     w_count;
    logic [ADDR_WIDTH-1:0]   w_ptr_inc;
    logic [DATA_WIDTH-1:0]   w_rd_final;
    logic                    w_sum_ok;

    // Requests larger than the address space cannot be stored distinctly.
    assign w_count    = (word_count > MAX_COUNT) ? MAX_COUNT : word_count;
    assign w_ptr_inc  = r_ptr + PTR_ONE;
    assign w_rd_final = r_rd_sum + mem_rdata;
    assign w_sum_ok   = (w_rd_final == r_load_sum) && (r_load_sum == r_exp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_rem       <= '0;
            r_count     <= '0;
            r_base      <= '0;
            r_exp       <= '0;
            r_load_sum  <= '0;
            r_rd_sum    <= '0;
            r_in_ready  <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_cs    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_oe    <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cpu_run   <= 1'b0;
            r_start_pc  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        r_base     <= base_addr;
                        r_exp      <= expected_sum;
                        r_load_sum <= '0;
                        r_rd_sum   <= '0;
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
                        r_cpu_run  <= 1'b0;
                        r_mem_cs   <= 1'b0;
                        r_mem_we   <= 1'b0;
                        r_mem_oe   <= 1'b1;
                        if (w_count == CNT_ZERO) begin
                            if (expected_sum == SUM_ZERO) begin
                                r_state    <= S_DONE;
                                r_done     <= 1'b1;
                                r_cpu_run  <= 1'b1;
                                r_start_pc <= base_addr;
                            end else begin
                                r_state <= S_ERROR;
                                r_err   <= 1'b1;
                            end
                        end else begin
                            r_ptr      <= base_addr;
                            r_rem      <= w_count;
                            r_count    <= w_count;
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b1;
                            r_state    <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (r_rem == CNT_ZERO) begin
                        // Final write strobe is on the bus now; set up the first read.
                        r_mem_cs   <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_oe   <= 1'b1;
                        r_mem_addr <= r_base;
                        r_ptr      <= r_base;
                        r_rem      <= r_count;
                        r_state    <= S_VADDR;
                    end else if (in_valid && r_in_ready) begin
                        r_mem_cs    <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_oe    <= 1'b0;
                        r_mem_addr  <= r_ptr;
                        r_mem_wdata <= in_data;
                        r_ptr       <= w_ptr_inc;
                        r_rem       <= r_rem - CNT_ONE;
                        r_load_sum  <= r_load_sum + in_data;
                        if (r_rem == CNT_ONE) begin
                            r_in_ready <= 1'b0;
                        end
                    end else begin
                        r_mem_cs <= 1'b0;
                        r_mem_we <= 1'b0;
                        r_mem_oe <= 1'b1;
                    end
                end
                S_VADDR: begin
                    r_state <= S_VDATA;
                end
                S_VDATA: begin
                    r_rd_sum <= w_rd_final;
                    r_ptr    <= w_ptr_inc;
                    r_rem    <= r_rem - CNT_ONE;
                    if (r_rem > CNT_ONE) begin
                        r_mem_addr <= w_ptr_inc;
                        r_state    <= S_VADDR;
                    end else begin
                        r_mem_cs <= 1'b0;
                        r_busy   <= 1'b0;
                        if (w_sum_ok) begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_cpu_run  <= 1'b1;
                            r_start_pc <= r_base;
                        end else begin
                            r_state <= S_ERROR;
                            r_err   <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_cs    = r_mem_cs;
    assign mem_we    = r_mem_we;
    assign mem_oe    = r_mem_oe;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign cpu_run   = r_cpu_run;
    assign start_pc  = r_start_pc;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: synchronous RAM model, timeline-based reference model
// checked every cycle, plus directed tests with hand-computed expectations.
module tb_prog_loader;

    localparam int AW    = 14;
    localparam int CW    = AW + 1;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   word_count = '0;
    logic [DW-1:0] expected_sum = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_cs, mem_we, mem_oe, busy, done, err, cpu_run;
    logic [AW-1:0] start_pc;

    always #5 clk = ~clk;

    prog_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .word_count(word_count), .expected_sum(expected_sum),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe), .busy(busy),
        .done(done), .err(err), .cpu_run(cpu_run), .start_pc(start_pc)
    );

    // Single-port synchronous RAM, one-cycle read latency
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_cs && mem_we && !mem_oe) ram[mem_addr] <= mem_wdata;
        if (mem_cs && !mem_we) mem_rdata <= ram[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a transaction is a timeline. t0 = first busy cycle,
    // vstart = first readback cycle, fin = first cycle showing the result.
    int            m_t0 = 0, m_fin = 0, m_vstart = 0, m_n = 0, m_acc = 0;
    bit            m_res_valid = 1'b0, m_res = 1'b0, m_beat_prev = 1'b0;
    logic [AW-1:0] m_base = '0, m_beat_addr = '0;
    logic [DW-1:0] m_sum = '0, m_exp = '0, m_beat_data = '0;

    always @(negedge clk) begin
        int            x;
        bit            busy_e, loading, in_res, beat;
        logic [AW-1:0] a;
        x = cyc;
        if (rst) begin
            chk("rst_in_ready", 32'(in_ready), 32'(0));
            chk("rst_mem_cs", 32'(mem_cs), 32'(0));
            chk("rst_mem_we", 32'(mem_we), 32'(0));
            chk("rst_mem_oe", 32'(mem_oe), 32'(1));
            chk("rst_mem_addr", 32'(mem_addr), 32'(0));
            chk("rst_mem_wdata", 32'(mem_wdata), 32'(0));
            chk("rst_busy", 32'(busy), 32'(0));
            chk("rst_done", 32'(done), 32'(0));
            chk("rst_err", 32'(err), 32'(0));
            chk("rst_cpu_run", 32'(cpu_run), 32'(0));
            chk("rst_start_pc", 32'(start_pc), 32'(0));
            m_t0 = 0; m_fin = 0; m_vstart = 0; m_n = 0; m_acc = 0;
            m_res_valid = 1'b0; m_beat_prev = 1'b0;
        end else begin
            busy_e  = (x >= m_t0) && (m_fin < 0 || x < m_fin);
            loading = busy_e && (m_acc < m_n);
            in_res  = (m_fin >= 0) && (x >= m_fin);
            chk("busy", 32'(busy), 32'(busy_e));
            chk("in_ready", 32'(in_ready), 32'(loading));
            chk("done", 32'(done), 32'(in_res && m_res_valid && m_res));
            chk("err", 32'(err), 32'(in_res && m_res_valid && !m_res));
            chk("cpu_run", 32'(cpu_run), 32'(in_res && m_res_valid && m_res));
            if (in_res && m_res_valid && m_res) chk("start_pc", 32'(start_pc), 32'(m_base));
            chk("mem_we", 32'(mem_we), 32'(m_beat_prev));
            chk("mem_oe", 32'(mem_oe), 32'(!m_beat_prev));
            if (m_beat_prev) begin
                chk("wr_cs", 32'(mem_cs), 32'(1));
                chk("wr_addr", 32'(mem_addr), 32'(m_beat_addr));
                chk("wr_data", 32'(mem_wdata), 32'(m_beat_data));
            end
            if (m_fin >= 0 && x >= m_vstart && x < m_fin) begin
                a = m_base + AW'((x - m_vstart) / 2);
                chk("rd_cs", 32'(mem_cs), 32'(1));
                chk("rd_addr", 32'(mem_addr), 32'(a));
            end
            if (in_res) chk("res_cs", 32'(mem_cs), 32'(0));

            beat = loading && in_valid;
            m_beat_prev = beat;
            if (beat) begin
                m_beat_addr = m_base + AW'(m_acc);
                m_beat_data = in_data;
                m_sum       = m_sum + in_data;
                m_acc++;
                if (m_acc == m_n) begin
                    m_vstart    = x + 2;
                    m_fin       = x + 2 + 2 * m_n;
                    m_res       = (m_sum == m_exp);
                    m_res_valid = 1'b1;
                end
            end
            if (start && !busy_e) begin
                m_base = base_addr;
                m_exp  = expected_sum;
                m_t0   = x + 1;
                m_acc  = 0;
                m_sum  = '0;
                m_n    = (int'(word_count) > DEPTH) ? DEPTH : int'(word_count);
                if (m_n == 0) begin
                    m_fin = x + 1; m_vstart = x + 1;
                    m_res = (expected_sum == '0); m_res_valid = 1'b1;
                end else begin
                    m_fin = -1; m_res_valid = 1'b0;
                end
            end
        end
    end

    logic [DW-1:0] img [16] = '{16'h110C, 16'h210E, 16'h110D, 16'h310B, 16'h210D, 16'h110E,
                                16'h310F, 16'h210E, 16'h8400, 16'h9102, 16'h7000, 16'h0005,
                                16'h0007, 16'h0000, 16'h0000, 16'hFFFF};
    logic [DW-1:0] src [$];

    task automatic use_img();
        src.delete();
        for (int i = 0; i < 16; i++) src.push_back(img[i]);
    endtask

    // Start a load, stream src, wait for done/err; lat = cycles from start to result.
    task automatic run_load(input logic [AW-1:0] base, input int n, input logic [DW-1:0] exp,
                            input bit toggle, input bit poke, output int lat);
        int idx, k, t_start;
        bit fire;
        idx = 0; k = 0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; word_count = CW'(n); expected_sum = exp;
        @(negedge clk); t_start = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        while (idx < n && k < 400) begin
            in_valid = toggle ? (k % 2 == 0) : 1'b1;
            in_data  = in_valid ? src[idx] : 16'hDEAD;
            start    = poke && (k == 3);
            if (start) begin word_count = '0; expected_sum = 16'h1234; end
            @(negedge clk); fire = in_valid && in_ready;
            @(posedge clk); #1;
            if (fire) idx++;
            k++;
        end
        in_valid = 1'b0; start = 1'b0;
        k = 0;
        while (!(done || err) && k < 400) begin
            @(negedge clk); k++;
        end
        chk("result_seen", 32'(done || err), 32'(1));
        lat = cyc - t_start;
    endtask

    initial begin
        int lat, idx, k;
        bit fire;
        logic [DW-1:0] ref_words [4];
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_oe", 32'(mem_oe), 32'(1));
        chk("idle_in_ready", 32'(in_ready), 32'(0));

        // 1: multiply image, continuous valid
        use_img();
        run_load(14'h100, 16, 16'h7D77, 1'b0, 1'b0, lat);
        $display("load1 base=100 n=16 lat=%0d done=%0b pc=%h", lat, done, start_pc);
        chk("t1_lat", 32'(lat), 32'd50);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_cpu_run", 32'(cpu_run), 32'd1);
        chk("t1_pc", 32'(start_pc), 32'h100);
        chk("t1_ram10f", 32'(ram[14'h10F]), 32'hFFFF);
        chk("t1_ram100", 32'(ram[14'h100]), 32'h110C);

        // 2: same image, valid toggled every other cycle
        for (int i = 0; i < 16; i++) ram[14'h100 + i] = '0;
        run_load(14'h100, 16, 16'h7D77, 1'b1, 1'b0, lat);
        $display("load2 toggled lat=%0d done=%0b", lat, done);
        chk("t2_lat", 32'(lat), 32'd65);
        chk("t2_done", 32'(done), 32'd1);
        for (int i = 0; i < 16; i++) chk("t2_ram", 32'(ram[14'h100 + i]), 32'(img[i]));

        // 3: address wrap, with an ignored start while busy
        src.delete();
        for (int i = 1; i <= 4; i++) src.push_back(DW'(i));
        run_load(14'h3FFE, 4, 16'h000A, 1'b0, 1'b1, lat);
        $display("load3 wrap base=3FFE lat=%0d done=%0b pc=%h", lat, done, start_pc);
        chk("t3_lat", 32'(lat), 32'd14);
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_pc", 32'(start_pc), 32'h3FFE);
        ref_words = '{16'h1, 16'h2, 16'h3, 16'h4};
        chk("t3_ram3ffe", 32'(ram[14'h3FFE]), 32'(ref_words[0]));
        chk("t3_ram3fff", 32'(ram[14'h3FFF]), 32'(ref_words[1]));
        chk("t3_ram0000", 32'(ram[14'h0000]), 32'(ref_words[2]));
        chk("t3_ram0001", 32'(ram[14'h0001]), 32'(ref_words[3]));
        in_valid = 1'b1; in_data = 16'hBEEF;
        repeat (4) @(posedge clk);
        #1 in_valid = 1'b0;

        // 4: bad checksum -> err, held until next start
        use_img();
        run_load(14'h100, 16, 16'h7D78, 1'b0, 1'b0, lat);
        $display("load4 badsum lat=%0d err=%0b cpu_run=%0b", lat, err, cpu_run);
        chk("t4_lat", 32'(lat), 32'd50);
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_cpu_run", 32'(cpu_run), 32'd0);
        repeat (10) @(negedge clk);
        chk("t4_err_hold", 32'(err), 32'd1);

        // 5: zero-length images
        run_load(14'h200, 0, 16'h0000, 1'b0, 1'b0, lat);
        $display("load5 n=0 sum=0 lat=%0d done=%0b", lat, done);
        chk("t5_lat", 32'(lat), 32'd1);
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_pc", 32'(start_pc), 32'h200);
        run_load(14'h200, 0, 16'h0005, 1'b0, 1'b0, lat);
        $display("load5b n=0 sum=5 lat=%0d err=%0b", lat, err);
        chk("t5b_err", 32'(err), 32'd1);

        // 6: reset after the 5th accepted word, then a fresh load
        @(posedge clk); #1;
        start = 1'b1; base_addr = 14'h100; word_count = CW'(16); expected_sum = 16'h7D77;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; idx = 0; k = 0;
        while (idx < 5 && k < 50) begin
            in_data = src[idx];
            @(negedge clk); fire = in_valid && in_ready;
            @(posedge clk); #1;
            if (fire) idx++;
            k++;
        end
        rst = 1'b1;
        #1;
        $display("reset mid-load after %0d words: we=%0b busy=%0b", idx, mem_we, busy);
        chk("t6_async_we", 32'(mem_we), 32'd0);
        chk("t6_async_ready", 32'(in_ready), 32'd0);
        chk("t6_async_busy", 32'(busy), 32'd0);
        chk("t6_async_oe", 32'(mem_oe), 32'd1);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run_load(14'h100, 16, 16'h7D77, 1'b0, 1'b0, lat);
        $display("load6 after reset lat=%0d done=%0b", lat, done);
        chk("t6_lat", 32'(lat), 32'd50);
        chk("t6_done", 32'(done), 32'd1);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
